miner_nonce_dispatch: RTL and testbench

Sequencer between the nonce counter and the SHA-256 hash core. It drives the counter's `clear` and `count_enable` inputs and latches each nonce with its rollover flag. For each nonce it streams the 16-word second message block of the 80-byte block header (merkle tail, time, nbits, nonce, padding, length) to the hash core over a valid/ready handshake. It reports busy and exhausted status to the host controller.

---
 rtl/miner_pkg.sv | 15 +
 rtl/miner_block2_mux.sv | 17 +
 rtl/miner_nonce_dispatch.sv | 111 +++++++++++
 tb/tb_miner_nonce_dispatch.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// miner_pkg: shared types and constants for the nonce dispatch path.
package miner_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_STREAM, S_ADVANCE, S_DONE
  } dispatch_state_t;
  typedef struct packed {
    logic [31:0] merkle_tail;
    logic [31:0] timestamp;
    logic [31:0] nbits;
  } hdr_fields_t;
  localparam logic [31:0] PAD_WORD = 32'h80000000;
  localparam logic [31:0] LEN_WORD = 32'h00000280;
  localparam int NUM_MSG_WORDS = 16;
  localparam logic [3:0] LAST_IDX = 4'(NUM_MSG_WORDS - 1);
endpackage

// File: rtl/miner_block2_mux.sv
// miner_block2_mux: selects one word of the second SHA-256 message block of the header.
module miner_block2_mux
  import miner_pkg::*;
(
  input  hdr_fields_t hdr,
  input  logic [31:0] nonce,
  input  logic [3:0]  idx,
  output logic [31:0] word
);
  always_comb
    word = idx == 4'd0     ? hdr.merkle_tail :
           idx == 4'd1     ? hdr.timestamp   :
           idx == 4'd2     ? hdr.nbits       :
           idx == 4'd3     ? nonce           :
           idx == 4'd4     ? PAD_WORD        :
           idx == LAST_IDX ? LEN_WORD        : 32'd0;
endmodule

// File: rtl/miner_nonce_dispatch.sv
// miner_nonce_dispatch: sequences the nonce counter and streams one header block per nonce
// to the hash core, reporting busy/exhausted status.
module miner_nonce_dispatch
  import miner_pkg::*;
#(
  parameter int NONCE_BITS = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           merkle_tail,
  input  logic [31:0]           timestamp,
  input  logic [31:0]           nbits,
  input  logic [NONCE_BITS-1:0] nonce_in,
  input  logic                  nonce_rollover,
  output logic                  count_clear,
  output logic                  count_enable,
  output logic [31:0]           word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [3:0]            word_index,
  output logic                  word_last,
  output logic [31:0]           cur_nonce,
  output logic                  busy,
  output logic                  exhausted
);
  dispatch_state_t state_q, state_d;
  hdr_fields_t hdr_q, hdr_d;
  logic [31:0] cur_nonce_q, cur_nonce_d;
  logic [3:0] idx_q, idx_d;
  logic last_q, last_d;
  logic stop_seen_q, stop_seen_d;
  logic [31:0] mux_word;
  logic accept;

  miner_block2_mux u_mux (
    .hdr   (hdr_q),
    .nonce (cur_nonce_q),
    .idx   (idx_q),
    .word  (mux_word)
  );

  assign accept = word_valid && word_ready;

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    cur_nonce_d = cur_nonce_q;
    idx_d       = idx_q;
    last_d      = last_q;
    stop_seen_d = stop_seen_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_CLEAR;
          hdr_d       = {merkle_tail, timestamp, nbits};
          stop_seen_d = 1'b0;
        end else if (stop && state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR:   state_d = stop ? S_IDLE : S_LOAD;
      S_LOAD: begin
        state_d     = stop ? S_IDLE : S_STREAM;
        cur_nonce_d = 32'(nonce_in);
        last_d      = nonce_rollover;
        idx_d       = 4'd0;
      end
      S_STREAM: begin
        stop_seen_d = stop_seen_q || stop;
        if (accept) begin
          idx_d = idx_q + 4'd1;
          // A stop only takes effect once the hash core has the whole block.
          if (idx_q == LAST_IDX)
            state_d = (stop_seen_q || stop) ? S_IDLE : last_q ? S_DONE : S_ADVANCE;
        end
      end
      S_ADVANCE: state_d = stop ? S_IDLE : S_LOAD;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      cur_nonce_q <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      cur_nonce_q <= cur_nonce_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  assign count_clear  = state_q == S_CLEAR;
  assign count_enable = state_q == S_ADVANCE && !stop;
  assign word_valid   = state_q == S_STREAM;
  assign word_out     = word_valid ? mux_word : 32'd0;
  assign word_index   = idx_q;
  assign word_last    = word_valid && idx_q == LAST_IDX;
  assign cur_nonce    = cur_nonce_q;
  assign busy         = state_q != S_IDLE && state_q != S_DONE;
  assign exhausted    = state_q == S_DONE;
endmodule

// File: tb/tb_miner_nonce_dispatch.sv
// tb_miner_nonce_dispatch: directed and randomized checks of the dispatcher against a block/counter model.
module tb_miner_nonce_dispatch;
  logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, stop = 1'b0, word_ready = 1'b0;
  logic [31:0] mt, ts, nbf, nonce_in, word_out, cur_nonce;
  logic nonce_rollover, count_clear, count_enable, word_valid, word_last, busy, exhausted;
  logic [3:0] word_index;
  logic [31:0] cnt, start_val, roll_val;
  int checks = 0, errors = 0;

  miner_nonce_dispatch dut (
    .clk(clk), .n_rst(n_rst), .start(start), .stop(stop),
    .merkle_tail(mt), .timestamp(ts), .nbits(nbf),
    .nonce_in(nonce_in), .nonce_rollover(nonce_rollover),
    .count_clear(count_clear), .count_enable(count_enable),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .word_index(word_index), .word_last(word_last), .cur_nonce(cur_nonce),
    .busy(busy), .exhausted(exhausted)
  );

  always #5 clk = ~clk;

  // Nonce counter: clear loads the job's start value, enable increments.
  always @(posedge clk or negedge n_rst)
    if (!n_rst) cnt <= '0;
    else if (count_clear) cnt <= start_val;
    else if (count_enable) cnt <= cnt + 32'd1;
  assign nonce_in = cnt;
  assign nonce_rollover = cnt == roll_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic start_job();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clear_pulse", count_clear, 1);
    chk("clear_busy", busy, 1);
    chk("clear_no_exh", exhausted, 0);
  endtask

  task automatic stream_block(input logic [31:0] nonce, input int pct,
                              input int hold_at, input int stop_at, input int abort_at);
    logic [31:0] w [16];
    int k = 0, n = 0, held = 0;
    bit seen = 0;
    w = '{default: 32'd0};
    w[0] = mt; w[1] = ts; w[2] = nbf; w[3] = nonce; w[4] = 32'h80000000; w[15] = 32'h00000280;
    while (k < 16 && n < 500) begin
      @(negedge clk);
      n++;
      if (k == abort_at) return;
      if (k == stop_at) stop = 1'b1;
      word_ready = $urandom_range(99) < pct;
      if (k == hold_at && held < 3 && word_valid) begin
        word_ready = 1'b0;
        held++;
        chk("hold_word", word_out, w[k]);
        chk("hold_index", word_index, k);
        chk("hold_valid", word_valid, 1);
      end
      chk("no_enable_in_block", count_enable, 0);
      chk("no_clear_in_block", count_clear, 0);
      if (seen) chk("valid_held", word_valid, 1);
      if (word_valid) seen = 1;
      if (word_valid && word_ready) begin
        chk("word", word_out, w[k]);
        chk("index", word_index, k);
        chk("last", word_last, k == 15);
        chk("cur_nonce", cur_nonce, nonce);
        k++;
      end
    end
    chk("block_complete", k, 16);
  endtask

  // kind 0: next nonce follows, 1: job exhausted, 2: aborted to idle
  task automatic after_block(input int kind);
    @(negedge clk);
    if (kind == 0) begin
      chk("advance_pulse", count_enable, 1);
      chk("advance_busy", busy, 1);
      @(negedge clk);
      chk("load_no_enable", count_enable, 0);
      chk("load_busy", busy, 1);
    end else begin
      chk("end_valid", word_valid, 0);
      chk("end_busy", busy, 0);
      chk("end_exhausted", exhausted, kind == 1);
      @(negedge clk);
      chk("end_no_enable", count_enable, 0);
      chk("end_exhausted2", exhausted, kind == 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int nblk;
    mt = '0; ts = '0; nbf = '0; start_val = '0; roll_val = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_clear", count_clear, 0);
    chk("rst_enable", count_enable, 0);
    chk("rst_exhausted", exhausted, 0);
    chk("rst_word", word_out, 0);
    chk("rst_index", word_index, 0);
    chk("rst_last", word_last, 0);
    chk("rst_nonce", cur_nonce, 0);
    n_rst = 1'b1;

    mt = 32'hDEADBEEF; ts = 32'h5543A1B0; nbf = 32'h1806B99F;
    start_val = 32'h00907AFB; roll_val = 32'hFFFFFFFF; word_ready = 1'b1;
    start_job();
    stream_block(32'h00907AFB, 100, -1, -1, -1);
    after_block(0);
    stream_block(32'h00907AFC, 100, 3, -1, -1);
    after_block(0);
    stream_block(32'h00907AFD, 100, -1, 7, -1);
    after_block(2);
    stop = 1'b0;

    mt = $urandom; ts = $urandom; nbf = $urandom;
    roll_val = start_val + 32'd1;
    start_job();
    stream_block(32'h00907AFB, 60, -1, -1, -1);
    after_block(0);
    stream_block(32'h00907AFC, 60, -1, -1, -1);
    after_block(1);

    stop = 1'b1;
    start_job();
    stop = 1'b0;
    stream_block(32'h00907AFB, 100, -1, -1, -1);
    after_block(0);
    stream_block(32'h00907AFC, 80, -1, -1, -1);
    after_block(1);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("done_stop_busy", busy, 0);
    chk("done_stop_exh", exhausted, 0);

    roll_val = 32'hFFFFFFFF;
    start_job();
    stream_block(32'h00907AFB, 100, -1, -1, 5);
    chk("pre_rst_index", word_index, 5);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", word_valid, 0);
    chk("mid_rst_index", word_index, 0);
    chk("mid_rst_word", word_out, 0);
    chk("mid_rst_last", word_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_nonce", cur_nonce, 0);
    chk("mid_rst_ctrl", {count_clear, count_enable, exhausted}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    mt = $urandom; ts = $urandom; nbf = $urandom;
    start_job();
    stream_block(32'h00907AFB, 50, -1, -1, -1);
    after_block(0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("load_stop_busy", busy, 0);
    chk("load_stop_valid", word_valid, 0);

    for (int j = 0; j < 4; j++) begin
      mt = $urandom; ts = $urandom; nbf = $urandom;
      start_val = $urandom;
      nblk = 1 + int'($urandom_range(2));
      roll_val = start_val + 32'(nblk - 1);
      start_job();
      for (int b = 0; b < nblk; b++) begin
        stream_block(start_val + 32'(b), 30 + int'($urandom_range(70)), -1, -1, -1);
        after_block(b == nblk - 1 ? 1 : 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
